// File: rtl/fetch_queue_if.sv
// IF -> ID fetch queue bus: instruction push side from IF, head entry side to ID,
// plus the flush/stall controls from the BTB and ID.
interface fetch_queue_if #(
    parameter int unsigned PTR_W = 3
);
    logic             FLUSH;
    logic             STALL;
    logic             Valid_IN;
    logic [31:0]      Instr1_IN;
    logic [31:0]      Instr_PC_IN;
    logic [31:0]      Instr_PC_Plus4_IN;
    logic             Full_OUT;
    logic             Valid_OUT;
    logic [31:0]      Instr1_OUT;
    logic [31:0]      Instr_PC_OUT;
    logic [31:0]      Instr_PC_Plus4_OUT;
    logic [PTR_W:0]   Count_OUT;

    // Pipeline side (IF/ID/BTB) driving the queue
    modport master (
        output FLUSH, STALL, Valid_IN, Instr1_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
        input  Full_OUT, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Count_OUT
    );

    // The queue itself
    modport slave (
        input  FLUSH, STALL, Valid_IN, Instr1_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
        output Full_OUT, Valid_OUT, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Count_OUT
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupling instruction queue between IF and ID. Circular buffer of
// {instr, pc, pc4}; head entry is presented combinationally, no empty bypass.
// FLUSH empties the queue in one cycle and discards that cycle's push/pop.
module fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    fetch_queue_if.slave fq
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      pc4_q   [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic show;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = !empty && !fq.STALL;
    assign push  = fq.Valid_IN && (!full || pop);

    // Next-state pointers and occupancy; FLUSH discards the cycle's push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fq.FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Pointer, occupancy and entry-valid registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push && !fq.FLUSH) vld_q[tail_q] <= 1'b1;
        end
    end

    // Entry storage; contents are not reset, reachability is governed by count
    always_ff @(posedge CLK) begin
        if (!RESET && !fq.FLUSH && push) begin
            instr_q[tail_q] <= fq.Instr1_IN;
            pc_q[tail_q]    <= fq.Instr_PC_IN;
            pc4_q[tail_q]   <= fq.Instr_PC_Plus4_IN;
        end
    end

    assign show = !empty && vld_q[head_q];

    assign fq.Valid_OUT          = !empty;
    assign fq.Full_OUT           = full;
    assign fq.Count_OUT          = count_q;
    assign fq.Instr1_OUT         = show ? instr_q[head_q] : '0;
    assign fq.Instr_PC_OUT       = show ? pc_q[head_q]    : '0;
    assign fq.Instr_PC_Plus4_OUT = show ? pc4_q[head_q]   : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus process maintains an ordered
// list of expected queue contents; a negedge monitor compares the DUT head,
// occupancy and flags against it.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    ent_t sb_q[$];
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .fq    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the presented head entry against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            int   n;
            ent_t e;
            n = sb_q.size();
            if (n > 0) e = sb_q[0];
            else e = '{instr: 32'h0, pc: 32'h0, pc4: 32'h0};
            chk("count", 32'(bus.Count_OUT), 32'(n));
            chk("valid", 32'(bus.Valid_OUT), 32'(n != 0));
            chk("full",  32'(bus.Full_OUT),  32'(n == DEPTH));
            chk("instr", bus.Instr1_OUT,        e.instr);
            chk("pc",    bus.Instr_PC_OUT,      e.pc);
            chk("pc4",   bus.Instr_PC_Plus4_OUT, e.pc4);
        end
    end

    // One clock of stimulus; the scoreboard follows the queue rules at the edge
    task automatic step(input bit r, input bit f, input bit s, input bit v, input logic [31:0] pc);
        ent_t e;
        int   n;
        bit   pop;
        bit   push;
        e.instr = $urandom;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        rst                   = r;
        bus.FLUSH             = f;
        bus.STALL             = s;
        bus.Valid_IN          = v;
        bus.Instr1_IN         = e.instr;
        bus.Instr_PC_IN       = e.pc;
        bus.Instr_PC_Plus4_IN = e.pc4;
        @(posedge clk);
        n = sb_q.size();
        if (r || f) begin
            sb_q.delete();
        end else begin
            pop  = (n > 0) && !s;
            push = v && ((n < DEPTH) || pop);
            if (pop)  void'(sb_q.pop_front());
            if (push) sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.FLUSH = 1'b0;
        bus.STALL = 1'b0;
        bus.Valid_IN = 1'b0;
        bus.Instr1_IN = '0;
        bus.Instr_PC_IN = '0;
        bus.Instr_PC_Plus4_IN = '0;
        @(negedge clk);

        // Reset for two cycles while IF presents valid words
        step(1, 0, 0, 1, 32'h0000_0aa0);
        chk_en = 1'b1;
        step(1, 0, 0, 1, 32'h0000_0aa4);
        step(0, 0, 1, 0, 32'h0);

        // Streaming with no stall: occupancy stays at one
        step(0, 0, 0, 1, 32'h0040_0000);
        step(0, 0, 0, 1, 32'h0040_0004);
        step(0, 0, 0, 1, 32'h0040_0008);
        step(0, 0, 0, 0, 32'h0);

        // Fill under stall, rejected ninth push, then drain with re-presentation
        for (int unsigned i = 0; i < 8; i++) step(0, 0, 1, 1, 32'h100 + 32'(4 * i));
        step(0, 0, 1, 1, 32'h120);
        for (int unsigned i = 0; i < 8; i++) step(0, 0, 0, (i == 0), 32'h120);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Full with simultaneous push and pop; tail wraps
        for (int unsigned i = 0; i < 8; i++) step(0, 0, 1, 1, 32'h180 + 32'(4 * i));
        step(0, 0, 0, 1, 32'h200);
        for (int unsigned i = 0; i < 10; i++) step(0, 0, 0, 0, 32'h0);

        // Flush with a wrong-path push, then the redirected fetch
        for (int unsigned i = 0; i < 5; i++) step(0, 0, 1, 1, 32'h280 + 32'(4 * i));
        step(0, 1, 0, 1, 32'h300);
        step(0, 0, 1, 1, 32'h500);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Reset beats flush and stall; flush beats stall
        for (int unsigned i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h600 + 32'(4 * i));
        step(1, 1, 1, 1, 32'h700);
        for (int unsigned i = 0; i < 2; i++) step(0, 0, 1, 1, 32'h800 + 32'(4 * i));
        step(0, 1, 1, 1, 32'h900);
        step(0, 0, 1, 0, 32'h0);

        // Randomised traffic
        for (int unsigned i = 0; i < 1500; i++) begin
            bit r, f, s, v;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 99) < 45);
            v = ($urandom_range(0, 99) < 70);
            step(r, f, s, v, $urandom & 32'hffff_fffc);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
